instr_fetch: RTL

//   Fetch sequencer that fills the 16-bit instruction register.
//   On a fetch request from the control unit it reads the word at PC over a req/ack memory

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_pc_reg.sv | 47 ++++
 rtl/instr_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared definitions for the instruction fetch sequencer
//
// Purpose: fetch FSM state encoding and default address/data widths and reset PC
//          used by instr_fetch and pc_reg.
// Ports:   none (package).
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2
  } fetch_state_t;

  localparam int          AW_DEF       = 16;
  localparam int          DW_DEF       = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// rtl/instr_fetch_pc_reg.sv - program counter register with load and increment
//
// Purpose: AW-bit PC register. load has priority over inc; increment wraps mod 2^AW.
// Ports:
//   clk    in   system clock
//   rst_b  in   asynchronous reset, active low (PC <= RESET_PC)
//   load   in   load PC from ld_val
//   ld_val in   AW-bit load value
//   inc    in   post-increment PC
//   pc     out  current PC
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          load,
  input  logic [AW-1:0] ld_val,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_d;
  logic [AW-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = ld_val;
    end else if (inc) begin
      pc_d = pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch sequencer filling the instruction register
//
// Purpose: on fetch_go (in IDLE) reads the word at PC over a req/ack handshake,
//          presents it on ir_in with a one-cycle ir_en strobe, then post-increments PC.
//          pc_load redirects PC in any state and aborts an outstanding request.
//          A request with no ack for TIMEOUT cycles ends with a one-cycle fetch_err.
// Ports:
//   clk, rst_b           clock, asynchronous active-low reset
//   fetch_go             start one fetch (sampled in IDLE only)
//   pc_load, pc_in       PC redirect
//   mem_req, mem_addr    read request level and address (= PC)
//   mem_ack, mem_rdata   one-cycle read response
//   ir_en, ir_in         IR load strobe and registered instruction word
//   pc_out               current PC
//   busy                 high outside IDLE
//   fetch_err            one-cycle timeout pulse
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
  parameter int            TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          fetch_go,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ir_en,
  output logic [DW-1:0] ir_in,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          fetch_err
);

  // Last REQ cycle before giving up: mem_req is high for exactly TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  fetch_state_t  state_d, state_q;
  logic [7:0]    cnt_d, cnt_q;
  logic [DW-1:0] ir_in_d, ir_in_q;
  logic          fetch_err_d, fetch_err_q;
  logic          pc_inc;
  logic [AW-1:0] pc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_in_d     = ir_in_q;
    fetch_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A redirect in the same cycle suppresses the fetch request.
        if (!pc_load && fetch_go) begin
          state_d = ST_REQ;
          cnt_d   = 8'd0;
        end
      end
      ST_REQ: begin
        if (pc_load) begin
          // Abort: any simultaneous ack is dropped.
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          ir_in_d = mem_rdata;
          state_d = ST_LOAD;
        end else if (cnt_q == TMO_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      ir_in_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ir_in_q     <= ir_in_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Redirect always wins; otherwise PC advances at the end of the LOAD cycle.
  assign pc_inc = (state_q == ST_LOAD);

  pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_b  (rst_b),
    .load   (pc_load),
    .ld_val (pc_in),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = pc;
  assign ir_en     = (state_q == ST_LOAD);
  assign ir_in     = ir_in_q;
  assign pc_out    = pc;
  assign busy      = (state_q != ST_IDLE);
  assign fetch_err = fetch_err_q;

endmodule
